// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-path definitions: coefficient type, block size, zigzag order table.
package jpeg_pkg;

    localparam int unsigned COEF_W  = 11;
    localparam int unsigned BLOCK_N = 64;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Raster address (8*row + col) of the k-th coefficient in zigzag order.
    localparam logic [5:0] ZIGZAG [BLOCK_N] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag-to-raster address lookup.
module zigzag_rom
    import jpeg_pkg::*;
(
    input  logic [5:0] k_i,
    output logic [5:0] addr_o
);

    // Table lookup of the raster address for zigzag position k.
    always_comb begin
        addr_o = ZIGZAG[k_i];
    end

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 block buffer: accepts coefficients in raster order, re-emits them in
// zigzag order. One bank fills while the other drains, so streaming has no bubbles.
module zigzag_buffer
    import jpeg_pkg::*;
#(
    parameter int unsigned WIDTH = COEF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_in,
    output logic             rdy_out,
    input  logic [WIDTH-1:0] in,
    input  logic             rdy_in,
    output logic             ena_out,
    output logic [WIDTH-1:0] out,
    output logic             first
);

    localparam logic [5:0] LastIdx = 6'(BLOCK_N - 1);

    logic [WIDTH-1:0] mem_q [2][BLOCK_N];

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [5:0] wr_idx_q,  wr_idx_d;
    logic [5:0] rd_k_q,    rd_k_d;
    logic [1:0] full_q,    full_d;

    logic       wr_fire;
    logic       rd_fire;
    logic       wr_last;
    logic       rd_last;
    logic [5:0] rd_addr;

    zigzag_rom u_zigzag_rom (
        .k_i    (rd_k_q),
        .addr_o (rd_addr)
    );

    // Handshakes are combinational on the registered full flags.
    always_comb begin
        rdy_out = !full_q[wr_bank_q];
        ena_out = rdy_in && full_q[rd_bank_q];
        wr_fire = ena_in && rdy_out;
        rd_fire = ena_out;
        wr_last = wr_fire && (wr_idx_q == LastIdx);
        rd_last = rd_fire && (rd_k_q == LastIdx);
        first   = ena_out && (rd_k_q == 6'd0);
        out     = mem_q[rd_bank_q][rd_addr];
    end

    // Pointer and full-flag next state; write and read completions always hit different
    // banks (write needs its bank empty, read needs its bank full), so both may apply.
    always_comb begin
        wr_idx_d  = wr_fire ? wr_idx_q + 6'd1 : wr_idx_q;
        rd_k_d    = rd_fire ? rd_k_q + 6'd1 : rd_k_q;
        wr_bank_d = wr_bank_q ^ wr_last;
        rd_bank_d = rd_bank_q ^ rd_last;
        full_d    = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Control state with asynchronous reset; stored blocks are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= 6'd0;
            rd_k_q    <= 6'd0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_k_q    <= rd_k_d;
            full_q    <= full_d;
        end
    end

    // Coefficient storage; contents need no reset since full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= in;
        end
    end

endmodule

// File: tb/tb_zigzag_buffer.sv
// Self-checking bench for zigzag_buffer against a block-level reference model.
module tb_zigzag_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [10:0] din = 11'd0;
    logic        rdy_out;
    logic        ena_out;
    logic [10:0] dout;
    logic        first;

    zigzag_buffer #(
        .WIDTH (11)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_in  (ena_in),
        .rdy_out (rdy_out),
        .in      (din),
        .rdy_in  (rdy_in),
        .ena_out (ena_out),
        .out     (dout),
        .first   (first)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: zigzag order derived by walking anti-diagonals.
    int          zz [64];
    logic [10:0] cur [64];
    logic [10:0] exp_q [$];
    int          wr_cnt;
    int          rd_cnt;
    int          full_blocks;

    logic        o_rdy, o_ena, o_first;
    logic [10:0] o_out;
    logic        x_rdy, x_ena, x_first;
    logic [10:0] x_out;

    function automatic void build_zigzag();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[k] = 8 * r + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[k] = 8 * r + (s - r);
                    k++;
                end
            end
        end
    endfunction

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        full_blocks = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, sample outputs at the falling edge, advance the model.
    task automatic cycle(input logic e, input logic [10:0] d, input logic r);
        ena_in = e;
        din = d;
        rdy_in = r;
        @(negedge clk);
        o_rdy = rdy_out;
        o_ena = ena_out;
        o_out = dout;
        o_first = first;
        x_rdy = (full_blocks < 2);
        x_ena = r && (full_blocks > 0);
        x_first = x_ena && (rd_cnt == 0);
        x_out = 11'd0;
        if (x_ena) begin
            x_out = exp_q.pop_front();
            rd_cnt++;
            if (rd_cnt == 64) begin
                rd_cnt = 0;
                full_blocks--;
            end
        end
        if (e && x_rdy) begin
            cur[wr_cnt] = d;
            wr_cnt++;
            if (wr_cnt == 64) begin
                for (int k = 0; k < 64; k++) exp_q.push_back(cur[zz[k]]);
                full_blocks++;
                wr_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy_in = 1'b1;
        ena_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rdy_out !== 1'b1 || ena_out !== 1'b0 || first !== 1'b0) begin
            bad++;
            $display("FAIL reset_in: rdy_out=%b ena_out=%b first=%b want 1 0 0",
                     rdy_out, ena_out, first);
        end
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 11'd0, 1'b1);
        total++;
        if (o_rdy !== 1'b1 || o_ena !== 1'b0 || o_first !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: rdy_out=%b ena_out=%b first=%b want 1 0 0",
                     o_rdy, o_ena, o_first);
        end
    endtask

    task automatic test_single_block();
        int lat = -1;
        int firsts = 0;
        int xfers = 0;
        for (int i = 0; i < 64 + 70; i++) begin
            cycle(i < 64, 11'(i), 1'b1);
            if (i >= 64 && o_ena && lat < 0) lat = i - 63;
            if (o_first) firsts++;
            if (o_ena) xfers++;
            total++;
            if (o_ena !== x_ena || o_rdy !== x_rdy || o_first !== x_first) begin
                bad++;
                $display("FAIL single_hs: ena/rdy/first=%b%b%b want %b%b%b",
                         o_ena, o_rdy, o_first, x_ena, x_rdy, x_first);
            end
            if (x_ena) begin
                total++;
                if (o_out !== x_out) begin
                    bad++;
                    $display("FAIL single_data: out=%0d want %0d", o_out, x_out);
                end
            end
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL single_latency: ena_out rose %0d cycles after last write, want 1", lat);
        end
        total++;
        if (firsts !== 1 || xfers !== 64) begin
            bad++;
            $display("FAIL single_count: first=%0d transfers=%0d want 1 64", firsts, xfers);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_low = 0;
        int t_first = -1;
        int t_last = -1;
        int xfers = 0;
        logic [10:0] v;
        for (int i = 0; i < 192 + 80; i++) begin
            if (i < 64) v = 11'(i);
            else if (i < 128) v = 11'(100 + i - 64);
            else v = 11'(-64 + i - 128);
            cycle(i < 192, v, 1'b1);
            if (i < 192 && !o_rdy) rdy_low++;
            if (o_ena) begin
                if (t_first < 0) t_first = i;
                t_last = i;
                xfers++;
            end
            total++;
            if (o_ena !== x_ena || o_rdy !== x_rdy || o_first !== x_first) begin
                bad++;
                $display("FAIL b2b_hs: ena/rdy/first=%b%b%b want %b%b%b",
                         o_ena, o_rdy, o_first, x_ena, x_rdy, x_first);
            end
            if (x_ena) begin
                total++;
                if (o_out !== x_out) begin
                    bad++;
                    $display("FAIL b2b_data: out=%0d want %0d", $signed(o_out), $signed(x_out));
                end
            end
        end
        total++;
        if (rdy_low !== 0) begin
            bad++;
            $display("FAIL b2b_rdy: rdy_out low %0d cycles, want 0", rdy_low);
        end
        total++;
        if (xfers !== 192 || t_last - t_first + 1 !== 192) begin
            bad++;
            $display("FAIL b2b_gaps: transfers=%0d span=%0d want 192 192",
                     xfers, t_last - t_first + 1);
        end
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        int writes = 0;
        logic r;
        for (int i = 0; i < 64; i++) cycle(1'b1, 11'($urandom), 1'b0);
        for (int i = 0; i < 1000 && (writes < 64 || full_blocks > 0); i++) begin
            r = 1'($urandom % 2);
            cycle(writes < 64, 11'($urandom), r);
            if (writes < 64 && x_rdy) writes++;
            if (o_ena) xfers++;
            total++;
            if (o_ena !== x_ena || o_rdy !== x_rdy || o_first !== x_first) begin
                bad++;
                $display("FAIL bp_hs: rdy_in=%b ena/rdy/first=%b%b%b want %b%b%b",
                         r, o_ena, o_rdy, o_first, x_ena, x_rdy, x_first);
            end
            if (x_ena) begin
                total++;
                if (o_out !== x_out) begin
                    bad++;
                    $display("FAIL bp_data: out=%0d want %0d", $signed(o_out), $signed(x_out));
                end
            end
        end
        total++;
        if (xfers !== 128) begin
            bad++;
            $display("FAIL bp_count: transfers=%0d want 128", xfers);
        end
    endtask

    task automatic test_both_full();
        int rise_at = -1;
        for (int i = 0; i < 128; i++) cycle(1'b1, 11'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 11'h2AA, 1'b0);
            total++;
            if (o_rdy !== 1'b0 || o_ena !== 1'b0) begin
                bad++;
                $display("FAIL full_block: rdy_out=%b ena_out=%b want 0 0", o_rdy, o_ena);
            end
        end
        for (int i = 0; i < 128 + 140; i++) begin
            cycle(i < 128, 11'(500 + i), 1'b1);
            if (o_rdy && rise_at < 0) rise_at = i;
            total++;
            if (o_ena !== x_ena || o_rdy !== x_rdy || o_first !== x_first) begin
                bad++;
                $display("FAIL full_hs: ena/rdy/first=%b%b%b want %b%b%b",
                         o_ena, o_rdy, o_first, x_ena, x_rdy, x_first);
            end
            if (x_ena) begin
                total++;
                if (o_out !== x_out) begin
                    bad++;
                    $display("FAIL full_data: out=%0d want %0d", o_out, x_out);
                end
            end
        end
        total++;
        if (rise_at !== 64) begin
            bad++;
            $display("FAIL full_rdy_return: rdy_out rose at read cycle %0d want 64", rise_at);
        end
    endtask

    task automatic test_sign_width();
        int k = 0;
        logic [10:0] v;
        for (int i = 0; i < 64 + 70; i++) begin
            v = 11'd0;
            if (i == 8) v = 11'h400;
            if (i == 63) v = 11'h3FF;
            cycle(i < 64, v, 1'b1);
            if (o_ena) begin
                total++;
                if (k == 2 && o_out !== 11'h400) begin
                    bad++;
                    $display("FAIL sign_k2: out=%0d want -1024", $signed(o_out));
                end else if (k == 63 && o_out !== 11'h3FF) begin
                    bad++;
                    $display("FAIL sign_k63: out=%0d want 1023", $signed(o_out));
                end else if (k != 2 && k != 63 && o_out !== 11'd0) begin
                    bad++;
                    $display("FAIL sign_zero: k=%0d out=%0d want 0", k, $signed(o_out));
                end
                k++;
            end
            total++;
            if (o_ena !== x_ena || o_first !== x_first) begin
                bad++;
                $display("FAIL sign_hs: ena/first=%b%b want %b%b", o_ena, o_first, x_ena, x_first);
            end
        end
        total++;
        if (k !== 64) begin
            bad++;
            $display("FAIL sign_count: transfers=%0d want 64", k);
        end
    endtask

    task automatic test_async_reset();
        int firsts = 0;
        for (int i = 0; i < 94; i++) cycle(1'b1, 11'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 11'd0, 1'b1);
        ena_in = 1'b0;
        rdy_in = 1'b1;
        #1;
        total++;
        if (ena_out !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre: ena_out=%b want 1", ena_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (ena_out !== 1'b0 || rdy_out !== 1'b1 || first !== 1'b0) begin
            bad++;
            $display("FAIL arst_now: ena_out=%b rdy_out=%b first=%b want 0 1 0",
                     ena_out, rdy_out, first);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 64 + 70; i++) begin
            cycle(i < 64, 11'($urandom), 1'b1);
            if (o_first) firsts++;
            total++;
            if (o_ena !== x_ena || o_rdy !== x_rdy || o_first !== x_first) begin
                bad++;
                $display("FAIL arst_hs: ena/rdy/first=%b%b%b want %b%b%b",
                         o_ena, o_rdy, o_first, x_ena, x_rdy, x_first);
            end
            if (x_ena) begin
                total++;
                if (o_out !== x_out) begin
                    bad++;
                    $display("FAIL arst_data: out=%0d want %0d", o_out, x_out);
                end
            end
        end
        total++;
        if (firsts !== 1) begin
            bad++;
            $display("FAIL arst_first: first pulses=%0d want 1", firsts);
        end
    endtask

    initial begin
        build_zigzag();
        model_reset();
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_both_full();
        test_sign_width();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
